wam_game_core: RTL and testbench

Parametrised whack-a-mole game engine, successor to the fixed 9-light, single-mode game top. It owns the game state machine, light sequencing, hit/miss detection, scoring, lives, countdown and level progression for N_HOLES lights and four game modes. It sits between the keypad controller (key_valid/key_idx) and the LED/HEX display drivers.

---
 rtl/wam_pkg.sv | 46 ++++
 rtl/wam_lfsr.sv | 32 +++
 rtl/wam_game_core.sv | 231 +++++++++++++++++++++++
 tb/tb_wam_game_core.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wam_pkg.sv
// Shared types and constants for the whack-a-mole game engine.
package wam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_ON   = 2'd2,
        ST_OVER = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_TIMED  = 2'd1,
        MODE_DEATH  = 2'd2,
        MODE_PROG   = 2'd3
    } mode_e;

    localparam logic [6:0]  HITS_NORMAL   = 7'd25;
    localparam logic [6:0]  HITS_EXTENDED = 7'd50;
    localparam logic [6:0]  SCORE_MAX     = 7'd99;
    localparam logic [1:0]  LEVEL_MAX     = 2'd3;

    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_ZERO_SUB = 16'hACE1;

    // Light-on duration per difficulty level, in quarter-second units.
    function automatic logic [3:0] on_units(input logic [1:0] lvl);
        case (lvl)
            2'd0:    on_units = 4'd8;
            2'd1:    on_units = 4'd4;
            2'd2:    on_units = 4'd4;
            default: on_units = 4'd2;
        endcase
    endfunction

    // Dark gap between lights per difficulty level, in quarter-second units.
    function automatic logic [3:0] gap_units(input logic [1:0] lvl);
        case (lvl)
            2'd0:    gap_units = 4'd8;
            2'd1:    gap_units = 4'd4;
            2'd2:    gap_units = 4'd2;
            default: gap_units = 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/wam_lfsr.sv
// 16-bit Galois LFSR used to pick the next light; a zero seed is replaced
// because the all-zero state would lock the sequence.
module wam_lfsr
    import wam_pkg::*;
(
    input  logic        clk_i,
    input  logic        load_i,
    input  logic [15:0] seed_i,
    input  logic        step_i,
    output logic [7:0]  rnd_o
);

    logic [15:0] lfsr_q, lfsr_d;

    // Load has priority over stepping; right-shifting Galois form.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == 16'h0000) ? LFSR_ZERO_SUB : seed_i;
        end else if (step_i) begin
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        lfsr_q <= lfsr_d;
    end

    assign rnd_o = lfsr_q[7:0];

endmodule

// File: rtl/wam_game_core.sv
// Whack-a-mole game engine: game FSM, light sequencing, hit/miss detection,
// scoring, lives, countdown and level progression for N_HOLES lights.
module wam_game_core
    import wam_pkg::*;
#(
    parameter int N_HOLES       = 9,
    parameter int TICKS_PER_Q   = 12_500_000,
    parameter int LIVES         = 3,
    parameter int LEVEL_UP_HITS = 5,
    parameter int GAME_SECONDS  = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [1:0]         level,
    input  logic               extended,
    input  logic [15:0]        seed,
    input  logic               key_valid,
    input  logic [3:0]         key_idx,
    output logic [N_HOLES-1:0] lights,
    output logic [6:0]         score,
    output logic [6:0]         max_hits,
    output logic [5:0]         time_left,
    output logic [1:0]         lives_left,
    output logic [1:0]         cur_level,
    output logic               game_over
);

    // Phase timer must hold the longest phase (8 quarter units).
    localparam int TW      = $clog2(8 * TICKS_PER_Q) + 1;
    localparam int SEC_LEN = 4 * TICKS_PER_Q;
    localparam int SW      = $clog2(SEC_LEN) + 1;
    localparam int HW      = $clog2(LEVEL_UP_HITS) + 1;

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [SW-1:0]       sec_q, sec_d;
    logic [HW-1:0]       hit_cnt_q, hit_cnt_d;
    logic [N_HOLES-1:0]  lights_q, lights_d;
    logic [6:0]          score_q, score_d;
    logic [6:0]          max_hits_q, max_hits_d;
    logic [6:0]          flicks_q, flicks_d;
    logic [5:0]          time_q, time_d;
    logic [1:0]          lives_q, lives_d;
    logic [1:0]          level_q, level_d;
    logic [3:0]          pos_q, pos_d;
    logic                pos_vld_q, pos_vld_d;

    logic [7:0]          rnd;
    logic                lfsr_step;
    logic [TW-1:0]       gap_len, on_len;
    logic [3:0]          p_raw, p_next;
    logic                hit, wrong, on_tout, gap_done, playing, flick_limited;

    wam_lfsr u_lfsr (
        .clk_i  (clk),
        .load_i (reset),
        .seed_i (seed),
        .step_i (lfsr_step),
        .rnd_o  (rnd)
    );

    // Phase lengths follow the current level; the level only changes on a
    // hit, which always starts a fresh GAP, so new timing lands there.
    always_comb begin
        gap_len = TW'(gap_units(level_q)) * TW'(TICKS_PER_Q);
        on_len  = TW'(on_units(level_q)) * TW'(TICKS_PER_Q);
    end

    // Next light position, skipping a repeat of the previous one.
    always_comb begin
        p_raw  = 4'(int'(rnd) % N_HOLES);
        p_next = p_raw;
        if (pos_vld_q && (p_raw == pos_q)) begin
            p_next = (int'(p_raw) == N_HOLES - 1) ? 4'd0 : p_raw + 4'd1;
        end
    end

    // Event decode for the current cycle.
    always_comb begin
        playing       = (state_q == ST_GAP) || (state_q == ST_ON);
        hit           = (state_q == ST_ON) && key_valid && (key_idx == pos_q);
        wrong         = (state_q == ST_ON) && key_valid && !hit;
        on_tout       = (state_q == ST_ON) && (timer_q == on_len - TW'(1));
        gap_done      = (state_q == ST_GAP) && (timer_q == gap_len - TW'(1));
        flick_limited = (mode_q == MODE_NORMAL) || (mode_q == MODE_PROG);
    end

    // Next-state and datapath updates; start overrides everything but reset.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        timer_d    = timer_q;
        sec_d      = sec_q;
        hit_cnt_d  = hit_cnt_q;
        lights_d   = lights_q;
        score_d    = score_q;
        max_hits_d = max_hits_q;
        flicks_d   = flicks_q;
        time_d     = time_q;
        lives_d    = lives_q;
        level_d    = level_q;
        pos_d      = pos_q;
        pos_vld_d  = pos_vld_q;
        lfsr_step  = 1'b0;

        case (state_q)
            ST_GAP: begin
                timer_d = timer_q + TW'(1);
                if (gap_done) begin
                    state_d   = ST_ON;
                    timer_d   = '0;
                    lights_d  = {{(N_HOLES-1){1'b0}}, 1'b1} << p_next;
                    pos_d     = p_next;
                    pos_vld_d = 1'b1;
                    lfsr_step = 1'b1;
                    if (flicks_q != 7'h7F) flicks_d = flicks_q + 7'd1;
                end
            end
            ST_ON: begin
                timer_d = timer_q + TW'(1);
                if (hit) begin
                    if (score_q != SCORE_MAX) score_d = score_q + 7'd1;
                    if (mode_q == MODE_PROG) begin
                        if (hit_cnt_q == HW'(LEVEL_UP_HITS - 1)) begin
                            hit_cnt_d = '0;
                            if (level_q != LEVEL_MAX) level_d = level_q + 2'd1;
                        end else begin
                            hit_cnt_d = hit_cnt_q + HW'(1);
                        end
                    end
                end
                // A hit or a timeout ends the flick.
                if (hit || on_tout) begin
                    lights_d = '0;
                    timer_d  = '0;
                    state_d  = (flick_limited && (flicks_q == max_hits_q)) ? ST_OVER : ST_GAP;
                end
                // Wrong key and timeout together still cost a single life.
                if ((mode_q == MODE_DEATH) && (wrong || (on_tout && !hit))) begin
                    lives_d = lives_q - 2'd1;
                    if (lives_q == 2'd1) begin
                        state_d  = ST_OVER;
                        lights_d = '0;
                    end
                end
            end
            default: ;
        endcase

        // Timed mode: one-second countdown while a game is running.
        if ((mode_q == MODE_TIMED) && playing) begin
            if (sec_q == SW'(SEC_LEN - 1)) begin
                sec_d  = '0;
                time_d = time_q - 6'd1;
                if (time_q == 6'd1) begin
                    state_d  = ST_OVER;
                    lights_d = '0;
                end
            end else begin
                sec_d = sec_q + SW'(1);
            end
        end

        if (start) begin
            state_d    = ST_GAP;
            mode_d     = mode_e'(mode);
            timer_d    = '0;
            sec_d      = '0;
            hit_cnt_d  = '0;
            lights_d   = '0;
            score_d    = '0;
            flicks_d   = '0;
            pos_vld_d  = 1'b0;
            max_hits_d = extended ? HITS_EXTENDED : HITS_NORMAL;
            level_d    = (mode_e'(mode) == MODE_PROG) ? 2'd0 : level;
            lives_d    = (mode_e'(mode) == MODE_DEATH) ? 2'(LIVES) : 2'd0;
            time_d     = (mode_e'(mode) == MODE_TIMED) ? 6'(GAME_SECONDS) : 6'd0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Game datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= MODE_NORMAL;
            timer_q    <= '0;
            sec_q      <= '0;
            hit_cnt_q  <= '0;
            lights_q   <= '0;
            score_q    <= '0;
            max_hits_q <= '0;
            flicks_q   <= '0;
            time_q     <= '0;
            lives_q    <= '0;
            level_q    <= '0;
            pos_q      <= '0;
            pos_vld_q  <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            timer_q    <= timer_d;
            sec_q      <= sec_d;
            hit_cnt_q  <= hit_cnt_d;
            lights_q   <= lights_d;
            score_q    <= score_d;
            max_hits_q <= max_hits_d;
            flicks_q   <= flicks_d;
            time_q     <= time_d;
            lives_q    <= lives_d;
            level_q    <= level_d;
            pos_q      <= pos_d;
            pos_vld_q  <= pos_vld_d;
        end
    end

    assign lights     = lights_q;
    assign score      = score_q;
    assign max_hits   = max_hits_q;
    assign time_left  = time_q;
    assign lives_left = lives_q;
    assign cur_level  = level_q;
    assign game_over  = (state_q == ST_OVER);

endmodule

// File: tb/tb_wam_game_core.sv
// Bench for wam_game_core: a cycle model derived from the game rules plus
// directed scenarios with hand-computed literal expectations.
module tb_wam_game_core;

    localparam int NH  = 9;
    localparam int TPQ = 4;
    localparam int LV  = 3;
    localparam int LUH = 2;
    localparam int GS  = 2;

    logic          clk = 1'b0;
    logic          reset, start, extended, key_valid;
    logic [1:0]    mode, level;
    logic [15:0]   seed;
    logic [3:0]    key_idx;
    logic [NH-1:0] lights;
    logic [6:0]    score, max_hits;
    logic [5:0]    time_left;
    logic [1:0]    lives_left, cur_level;
    logic          game_over;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    wam_game_core #(
        .N_HOLES(NH), .TICKS_PER_Q(TPQ), .LIVES(LV),
        .LEVEL_UP_HITS(LUH), .GAME_SECONDS(GS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .level(level),
        .extended(extended), .seed(seed), .key_valid(key_valid), .key_idx(key_idx),
        .lights(lights), .score(score), .max_hits(max_hits), .time_left(time_left),
        .lives_left(lives_left), .cur_level(cur_level), .game_over(game_over)
    );

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 gap, 2 on, 3 over; m_el = cycles spent in the phase.
    int          m_phase, m_el, m_score, m_flk, m_lives, m_time, m_play;
    int          m_lvl, m_hits, m_pos, m_posvld, m_light, m_mode, m_maxh;
    logic [15:0] m_lfsr;

    function automatic int on_cyc(input int l);
        int u[4] = '{8, 4, 4, 2};
        return u[l] * TPQ;
    endfunction

    function automatic int gap_cyc(input int l);
        int u[4] = '{8, 4, 2, 1};
        return u[l] * TPQ;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        if (s[0]) return (s >> 1) ^ 16'hB400;
        return s >> 1;
    endfunction

    task automatic model_step();
        bit was_play, hit, tout, miss;
        int p;
        if (reset) begin
            m_phase = 0; m_el = 0; m_score = 0; m_flk = 0; m_lives = 0;
            m_time = 0; m_play = 0; m_lvl = 0; m_hits = 0; m_pos = 0;
            m_posvld = 0; m_light = -1; m_mode = 0; m_maxh = 0;
            m_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
            return;
        end
        if (start) begin
            m_phase = 1; m_el = 0; m_score = 0; m_flk = 0; m_play = 0;
            m_hits = 0; m_posvld = 0; m_light = -1; m_mode = int'(mode);
            m_maxh  = extended ? 50 : 25;
            m_lvl   = (m_mode == 3) ? 0 : int'(level);
            m_lives = (m_mode == 2) ? LV : 0;
            m_time  = (m_mode == 1) ? GS : 0;
            return;
        end
        was_play = (m_phase == 1) || (m_phase == 2);
        if (m_phase == 1) begin
            m_el++;
            if (m_el == gap_cyc(m_lvl)) begin
                p = int'(m_lfsr[7:0]) % NH;
                if (m_posvld != 0 && p == m_pos) p = (p + 1) % NH;
                m_pos = p; m_posvld = 1; m_light = p;
                m_phase = 2; m_el = 0; m_flk++;
                m_lfsr = lfsr_next(m_lfsr);
            end
        end else if (m_phase == 2) begin
            m_el++;
            tout = (m_el == on_cyc(m_lvl));
            hit  = key_valid && (int'(key_idx) == m_pos);
            miss = !hit && (key_valid || tout);
            if (hit) begin
                m_score = (m_score < 99) ? m_score + 1 : 99;
                m_hits++;
                if (m_mode == 3) m_lvl = (m_hits / LUH > 3) ? 3 : m_hits / LUH;
            end
            if (hit || tout) begin
                m_light = -1; m_el = 0;
                m_phase = ((m_mode == 0 || m_mode == 3) && m_flk == m_maxh) ? 3 : 1;
            end
            if (m_mode == 2 && miss) begin
                m_lives--;
                if (m_lives == 0) begin m_phase = 3; m_light = -1; end
            end
        end
        if (m_mode == 1 && was_play) begin
            m_play++;
            m_time = GS - m_play / (4 * TPQ);
            if (m_time <= 0) begin m_time = 0; m_phase = 3; m_light = -1; end
        end
    endtask

    // Compare process: advance the model on each edge, compare 1 unit later.
    initial begin
        logic [NH-1:0] e_l;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            e_l = '0;
            if (m_light >= 0) e_l[m_light] = 1'b1;
            checks++;
            if (lights !== e_l || int'(score) != m_score || int'(max_hits) != m_maxh ||
                int'(time_left) != m_time || int'(lives_left) != m_lives ||
                int'(cur_level) != m_lvl || game_over !== (m_phase == 3)) begin
                fails++;
                $display("FAIL model_cmp t=%0t got l=%h s=%0d mh=%0d t=%0d lv=%0d cl=%0d go=%0b want l=%h s=%0d mh=%0d t=%0d lv=%0d cl=%0d go=%0b",
                         $time, lights, score, max_hits, time_left, lives_left, cur_level, game_over,
                         e_l, m_score, m_maxh, m_time, m_lives, m_lvl, (m_phase == 3));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(1); reset = 1'b0;
    endtask

    task automatic pulse_start(input logic [1:0] md, input logic [1:0] lv, input logic ex);
        mode = md; level = lv; extended = ex; start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic press(input int k);
        key_idx = 4'(k); key_valid = 1'b1; tick(1); key_valid = 1'b0;
    endtask

    task automatic wait_light(input string nm, output int cnt);
        cnt = 0;
        while (lights == '0 && cnt < 400) begin tick(1); cnt++; end
        if (lights == '0) begin
            checks++; fails++;
            $display("FAIL %s timeout waiting for light after %0d cycles", nm, cnt);
        end
    endtask

    task automatic wait_dark(input string nm, output int cnt);
        cnt = 0;
        while (lights != '0 && cnt < 400) begin tick(1); cnt++; end
        if (lights != '0) begin
            checks++; fails++;
            $display("FAIL %s timeout waiting for dark after %0d cycles", nm, cnt);
        end
    endtask

    task automatic wait_over(input string nm, output int cnt);
        cnt = 0;
        while (!game_over && cnt < 4000) begin tick(1); cnt++; end
        if (!game_over) begin
            checks++; fails++;
            $display("FAIL %s timeout waiting for game_over after %0d cycles", nm, cnt);
        end
    endtask

    function automatic int light_idx(input logic [NH-1:0] l);
        for (int i = 0; i < NH; i++) if (l[i]) return i;
        return 0;
    endfunction

    initial begin
        int c;
        int exp_gap[8] = '{32, 32, 16, 16, 8, 8, 4, 4};
        int exp_lvl[8] = '{0, 1, 1, 2, 2, 3, 3, 3};
        reset = 1'b1; start = 1'b0; mode = 2'd0; level = 2'd0; extended = 1'b0;
        seed = 16'h0000; key_valid = 1'b0; key_idx = 4'd0;
        tick(2);
        reset = 1'b0;
        check("rst_lights", int'(lights), 0);
        check("rst_over", int'(game_over), 0);
        check("rst_maxh", int'(max_hits), 0);

        // 1: normal, level 0, no keys. Seed 0 -> ACE1 -> positions 0, 4.
        pulse_start(2'd0, 2'd0, 1'b0);
        check("t1_maxh", int'(max_hits), 25);
        wait_light("t1_l1", c);  check("t1_gap", c, 32);
        check("t1_pos1", int'(lights), 9'h001);
        wait_dark("t1_d1", c);   check("t1_on", c, 32);
        wait_light("t1_l2", c);  check("t1_gap2", c, 32);
        check("t1_pos2", int'(lights), 9'h010);
        wait_over("t1_over", c); check("t1_over_at", c, 1504);
        check("t1_score", int'(score), 0);
        check("t1_dark", int'(lights), 0);

        // 2: hit 3 cycles into ON.
        do_reset();
        pulse_start(2'd0, 2'd0, 1'b0);
        wait_light("t2_l1", c);
        tick(3);
        press(0);
        check("t2_hit_dark", int'(lights), 0);
        check("t2_score", int'(score), 1);
        wait_light("t2_l2", c);  check("t2_gap", c, 32);
        check("t2_pos2", int'(lights), 9'h010);

        // 3: deathmatch.
        do_reset();
        pulse_start(2'd2, 2'd0, 1'b0);
        check("t3_lives0", int'(lives_left), 3);
        wait_light("t3_l1", c);
        press(15);
        check("t3_lives1", int'(lives_left), 2);
        check("t3_still_lit", int'(lights), 9'h001);
        wait_dark("t3_d1", c);   check("t3_on_rest", c, 31);
        check("t3_lives2", int'(lives_left), 1);
        wait_light("t3_l2", c);
        press(0);
        check("t3_lives3", int'(lives_left), 0);
        check("t3_over", int'(game_over), 1);
        check("t3_dark", int'(lights), 0);
        press(4);
        tick(50);
        check("t3_over_hold", int'(game_over), 1);
        check("t3_score_hold", int'(score), 0);

        // 4: timed, level 3 (gap 4 / on 8 cycles), 2 seconds = 32 cycles.
        do_reset();
        pulse_start(2'd1, 2'd3, 1'b0);
        check("t4_time2", int'(time_left), 2);
        tick(15); check("t4_time2b", int'(time_left), 2);
        tick(1);  check("t4_time1", int'(time_left), 1);
        tick(15); check("t4_time1b", int'(time_left), 1);
        check("t4_mid_on", int'(lights != '0), 1);
        tick(1);
        check("t4_time0", int'(time_left), 0);
        check("t4_over", int'(game_over), 1);
        check("t4_dark", int'(lights), 0);

        // 5: progression, level-up every 2 hits.
        do_reset();
        pulse_start(2'd3, 2'd2, 1'b0);
        check("t5_lvl_start", int'(cur_level), 0);
        for (int i = 0; i < 8; i++) begin
            wait_light("t5_l", c);
            check($sformatf("t5_gap%0d", i), c, exp_gap[i]);
            press(light_idx(lights));
            check($sformatf("t5_lvl%0d", i), int'(cur_level), exp_lvl[i]);
        end
        check("t5_score", int'(score), 8);
        wait_light("t5_l9", c);  check("t5_gap_l3", c, 4);
        wait_dark("t5_d9", c);   check("t5_on_l3", c, 8);

        // 6: hit on the timeout cycle, restart mid-ON, reset beats start.
        do_reset();
        pulse_start(2'd0, 2'd3, 1'b0);
        wait_light("t6_l1", c);  check("t6_gap", c, 4);
        tick(7);
        press(0);
        check("t6_score", int'(score), 1);
        check("t6_dark", int'(lights), 0);
        wait_light("t6_l2", c);
        tick(2);
        pulse_start(2'd0, 2'd0, 1'b1);
        check("t6_rs_score", int'(score), 0);
        check("t6_rs_dark", int'(lights), 0);
        check("t6_rs_over", int'(game_over), 0);
        check("t6_rs_maxh", int'(max_hits), 50);
        wait_light("t6_l3", c);  check("t6_rs_gap", c, 32);
        check("t6_pos3", int'(lights), 9'h004);
        mode = 2'd1; reset = 1'b1; start = 1'b1;
        tick(1);
        reset = 1'b0; start = 1'b0;
        check("t6_rst_dark", int'(lights), 0);
        check("t6_rst_time", int'(time_left), 0);
        tick(40);
        check("t6_idle_dark", int'(lights), 0);
        check("t6_idle_over", int'(game_over), 0);

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
